// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters: arbitrates, latches the byte, counts baud ticks to frame end.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GUARD_TICKS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_par,
    input  logic                   baud_tick,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    output logic                   uart_p_sel,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned BASE_LAST = 9 + GUARD_TICKS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]   frame_last;
    logic [IDX_W-1:0]   winner;
    logic [7:0]         win_data;
    logic               win_par;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Lowest asserted index wins; descending scan leaves the lowest one.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0]   last_ptr;
    logic               rr_found;

    // Search begins one past the last grant and wraps around.
    always_comb begin
        winner   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!rr_found && req[i] && (i == (int'(last_ptr) + k) % int'(NUM_REQ))) begin
                    winner   = IDX_W'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        win_data = '0;
        win_par  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == IDX_W'(i)) begin
                win_data = req_data[8*i +: 8];
                win_par  = req_par[i];
            end
        end
    end

    // Last counted tick index: start + 8 data + optional parity + stop + guard, minus one.
    assign frame_last = CNT_W'(BASE_LAST) + CNT_W'(uart_p_sel);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            uart_start <= 1'b0;
            uart_data  <= '0;
            uart_p_sel <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick_cnt   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_ptr   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            grant      <= '0;
            uart_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        uart_data  <= win_data;
                        uart_p_sel <= win_par;
                        grant      <= NUM_REQ'(1) << winner;
                        uart_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
`ifndef UART_ARB_FIXED_PRIO_EN
                        last_ptr   <= winner;
`endif
                    end
                end
                START: begin
                    tick_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (baud_tick) begin
                        if (tick_cnt == frame_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, GUARD_TICKS=1): transaction table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_par;
    logic        baud_tick;
    logic [3:0]  grant;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_p_sel;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GUARD_TICKS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_par    (req_par),
        .baud_tick  (baud_tick),
        .grant      (grant),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_p_sel (uart_p_sel),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  par;
        bit          tick_at_start;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
        logic        exp_par;
        int          exp_ticks;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Ticks every other cycle from a negedge until done shows; returns ticks issued.
    task automatic tick_until_done(output int ticks, output bit ok);
        ticks = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            check("busy_in_frame", 32'(busy), 32'd1);
            check("no_grant_in_frame", 32'(grant), 32'd0);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            ticks++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 32'(ok), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int ticks;
        bit ok;
        req      = v.req;
        req_data = v.data;
        req_par  = v.par;
        @(negedge clk);
        check({v.name, "_grant"}, 32'(grant), 32'(v.exp_grant));
        check({v.name, "_start"}, 32'(uart_start), 32'd1);
        check({v.name, "_busy"}, 32'(busy), 32'd1);
        check({v.name, "_data"}, 32'(uart_data), 32'(v.exp_data));
        check({v.name, "_psel"}, 32'(uart_p_sel), 32'(v.exp_par));
        req       = '0;
        baud_tick = v.tick_at_start;
        @(negedge clk);
        baud_tick = 1'b0;
        check({v.name, "_start_drop"}, 32'(uart_start), 32'd0);
        tick_until_done(ticks, ok);
        check({v.name, "_ticks"}, 32'(ticks), 32'(v.exp_ticks));
        @(negedge clk);
        check({v.name, "_done_pulse"}, 32'(done), 32'd0);
        check({v.name, "_data_hold"}, 32'(uart_data), 32'(v.exp_data));
    endtask

    initial begin
        int   ticks;
        bit   ok;
        int   n;
        logic [3:0] gnt_seen[5];
        int   gnt_cyc[5];
        logic [3:0] exp_order[5];

        vecs[0] = '{"single",   4'b0001, 32'h1122_33A5, 4'b0000, 1'b0, 4'b0001, 8'hA5, 1'b0, 11};
        vecs[1] = '{"parity",   4'b0100, 32'h443C_5566, 4'b0100, 1'b1, 4'b0100, 8'h3C, 1'b1, 12};
        vecs[2] = '{"req1",     4'b0010, 32'h7788_5A99, 4'b0001, 1'b0, 4'b0010, 8'h5A, 1'b0, 11};
`ifdef UART_ARB_FIXED_PRIO_EN
        vecs[3] = '{"pair_a",   4'b1001, 32'hC312_34E1, 4'b1000, 1'b0, 4'b0001, 8'hE1, 1'b0, 11};
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        vecs[3] = '{"pair_a",   4'b1001, 32'hC312_34E1, 4'b1000, 1'b0, 4'b1000, 8'hC3, 1'b1, 12};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        vecs[4] = '{"pair_b",   4'b1001, 32'h0F00_00F0, 4'b0001, 1'b0, 4'b0001, 8'hF0, 1'b1, 12};

        reset     = 1'b0;
        req       = '0;
        req_data  = '0;
        req_par   = '0;
        baud_tick = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_data", 32'(uart_data), 32'd0);
        check("rst_psel", 32'(uart_p_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Late request raised during WAIT, plus a one-cycle pulse that must be lost.
        req      = 4'b0001;
        req_data = 32'h0000_0011;
        req_par  = '0;
        @(negedge clk);
        check("late_first_grant", 32'(grant), 32'd1);
        req = '0;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b1010;
        @(negedge clk);
        req = 4'b0010;
        tick_until_done(ticks, ok);
        check("late_first_ticks", 32'(ticks), 32'd11);
        @(negedge clk);
        check("late_grant_after_done", 32'(grant), 32'b0010);
        check("late_start_after_done", 32'(uart_start), 32'd1);
        req = '0;
        @(negedge clk);
        tick_until_done(ticks, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("withdrawn_never_granted", 32'(grant), 32'd0);
        end

        // Back-to-back: req[0] held through done, new byte presented in the done cycle.
        req      = 4'b0001;
        req_data = 32'h0000_0081;
        @(negedge clk);
        check("b2b_first_data", 32'(uart_data), 32'h81);
        @(negedge clk);
        tick_until_done(ticks, ok);
        req_data = 32'h0000_0042;
        @(negedge clk);
        check("b2b_start_gap1", 32'(uart_start), 32'd1);
        check("b2b_grant", 32'(grant), 32'b0001);
        check("b2b_new_data", 32'(uart_data), 32'h42);
        check("b2b_done_single", 32'(done), 32'd0);
        req = '0;
        @(negedge clk);
        tick_until_done(ticks, ok);
        check("b2b_second_ticks", 32'(ticks), 32'd11);

        // Reset asserted mid-frame after five counted ticks.
        @(negedge clk);
        req      = 4'b0100;
        req_data = 32'h007E_0000;
        req_par  = 4'b0100;
        @(negedge clk);
        check("rmf_grant", 32'(grant), 32'b0100);
        req = '0;
        @(negedge clk);
        repeat (5) begin
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            @(negedge clk);
        end
        check("rmf_busy_before", 32'(busy), 32'd1);
        check("rmf_data_before", 32'(uart_data), 32'h7E);
        #2 reset = 1'b0;
        #1;
        check("rmf_async_busy", 32'(busy), 32'd0);
        check("rmf_async_data", 32'(uart_data), 32'd0);
        check("rmf_async_psel", 32'(uart_p_sel), 32'd0);
        check("rmf_async_grant_start", 32'({grant, uart_start}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            baud_tick = 1'b1;
            @(negedge clk);
            check("rmf_no_done", 32'(done), 32'd0);
        end
        baud_tick = 1'b0;
        reset     = 1'b1;
        req       = 4'b1111;
        req_par   = '0;
        @(negedge clk);
        check("rmf_req0_first", 32'(grant), 32'b0001);
        req = '0;
        @(negedge clk);
        tick_until_done(ticks, ok);

        // Contention: all four held, baud_tick every cycle, fresh pointer.
        do_reset();
        req       = 4'b1111;
        req_data  = 32'h4433_2211;
        req_par   = '0;
        baud_tick = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            @(negedge clk);
            if (grant != 4'b0000) begin
                gnt_seen[n] = grant;
                gnt_cyc[n]  = c;
                n++;
            end
        end
        check("cont_grant_count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) begin
            check("cont_order", 32'(gnt_seen[i]), 32'(exp_order[i]));
            if (i > 0) check("cont_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd13);
        end
        req = '0;
        ok  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("cont_final_done", 32'(ok), 32'd1);
        baud_tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
